instruction_fetch: RTL and testbench

Fetch stage of the core. Owns the program counter, drives the combinational instruction memory address, and captures `{pc, instruction}` pairs into a 2-entry buffer. The buffer presents a valid/ready stream to the decode stage. Accepts a single-cycle redirect from execute (branch/jump) that flushes buffered instructions and reloads the PC.

---
 rtl/core_pkg.sv | 30 +++
 rtl/fetch_buffer.sv | 86 ++++++++
 rtl/instruction_fetch.sv | 103 ++++++++++
 tb/tb_instruction_fetch.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// ---------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the front end of the core.
//   fetch_entry_t : one buffered fetch result, the PC and the instruction word
//                   that instruction memory returned for that PC.
//   NOP_INSTR     : canonical RISC-V NOP (addi x0,x0,0). It is shown on the
//                   decode interface while nothing valid is buffered.
//   PC_STEP       : sequential PC increment, one 32-bit instruction.
//   alignPc       : forces a byte address onto a 4-byte instruction boundary.
// ---------------------------------------------------------------------------
package core_pkg;

  localparam int DATA_WIDTH  = 64;
  localparam int INSTR_WIDTH = 32;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam logic [63:0] PC_STEP   = 64'd4;

  // Instructions are word aligned, so the two low address bits carry no
  // information and are always dropped.
  function automatic logic [63:0] alignPc(input logic [63:0] pc);
    return {pc[63:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// Small synchronous FIFO of fetch_entry_t sitting between fetch and decode.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset, empties the FIFO
//   flush     : synchronous clear, discards all entries and overrides push
//   push      : write push_data at the tail this cycle
//   push_data : entry to write
//   pop       : advance the head this cycle
//   head_data : oldest entry (only meaningful while not empty)
//   count     : number of entries held, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
// A push while full is accepted only when a pop happens in the same cycle,
// which keeps the FIFO at DEPTH entries and gives one entry per cycle.
// ---------------------------------------------------------------------------
module fetch_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  fetch_entry_t       push_data,
  input  logic               pop,
  output fetch_entry_t       head_data,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty
);

  fetch_entry_t     r_storage [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic w_doPush;
  logic w_doPop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

  // Guard against misuse: popping an empty FIFO is ignored, and a push into
  // a full FIFO only lands when the head is leaving in the same cycle.
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && !flush && (!full || w_doPop);

  assign head_data = r_storage[r_head];

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap for free when they overflow their width.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_doPop) begin
        r_head <= r_head + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it until an entry has been written,
  // because the consumer masks the head while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_storage[r_tail] <= push_data;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
// Fetch stage: owns the PC, addresses instruction memory, and captures
// {pc, instruction} pairs into fetch_buffer, which feeds decode through a
// valid/ready handshake. A one-cycle redirect from execute flushes the
// buffer and reloads the PC.
// Ports:
//   clk            : clock
//   rst            : synchronous active-high reset
//   imem_addr      : byte address to instruction memory (the PC register)
//   imem_instr     : instruction returned combinationally for imem_addr
//   redirect_valid : execute requests a PC change this cycle
//   redirect_pc    : redirect target, low two bits ignored
//   if_valid       : buffer head holds an instruction for decode
//   if_ready       : decode accepts the head this cycle
//   if_pc          : PC of the head instruction (0 when empty)
//   if_instr       : head instruction (NOP when empty)
//   if_pc_plus4    : if_pc + 4, wrapping at 2^64
// ---------------------------------------------------------------------------
module instruction_fetch
  import core_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          DEPTH    = 2,
  localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  input  logic                   redirect_valid,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [DATA_WIDTH-1:0]  if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [DATA_WIDTH-1:0]  if_pc_plus4
);

  logic [63:0]      r_pc;

  fetch_entry_t     w_pushData;
  fetch_entry_t     w_head;
  logic [CNT_W-1:0] w_count;
  logic             w_full;
  logic             w_empty;
  logic             w_pop;
  logic             w_push;

  // The PC is a register, so the memory address never depends on any input
  // in the current cycle.
  assign imem_addr = r_pc;

  // Decode sees the head only when the buffer holds something. Everything
  // here is derived from registered buffer state, so if_ready cannot reach
  // if_valid, if_pc or if_instr combinationally.
  assign if_valid    = !w_empty;
  assign if_pc       = w_empty ? 64'h0 : w_head.pc;
  assign if_instr    = w_empty ? NOP_INSTR : w_head.instr;
  assign if_pc_plus4 = if_pc + PC_STEP;

  // A pop during a redirect is still a handshake from decode's point of
  // view; the flush then throws the remaining contents away.
  assign w_pop = if_valid && if_ready;

  // Fetch a new instruction whenever there is room, or room is being made
  // by a pop this cycle. Reset and redirect both suppress the fetch, since
  // the word coming back belongs to a PC that is about to be abandoned.
  assign w_push = !rst && !redirect_valid && (!w_full || w_pop);

  assign w_pushData = '{pc: r_pc, instr: imem_instr};

  // PC update: reset beats redirect, redirect beats sequential advance, and
  // with no push the PC holds so the memory address stays stable on a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= alignPc(RESET_PC);
    end else if (redirect_valid) begin
      r_pc <= alignPc(redirect_pc);
    end else if (w_push) begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_fetchBuffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (w_push),
    .push_data (w_pushData),
    .pop       (w_pop),
    .head_data (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Occupancy can never exceed the configured depth.
  assert property (@(posedge clk) disable iff (rst) w_count <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
// Two fetch stages share one stimulus stream: one resets to PC 0, the other
// to the last word below 2^64 so the PC wrap is exercised. Each has its own
// combinational instruction memory and its own reference model, which keeps
// the PC and an ordered list of outstanding {pc, instr} entries.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam int          DEPTH     = 2;
  localparam logic [63:0] RESET_A   = 64'h0;
  localparam logic [63:0] RESET_W   = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] NOP       = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirectValid = 1'b0;
  logic [63:0] redirectPc = 64'h0;
  logic        ifReady = 1'b0;

  logic [63:0] imemAddrA, ifPcA, ifPcPlus4A;
  logic [31:0] imemInstrA, ifInstrA;
  logic        ifValidA;
  logic [63:0] imemAddrW, ifPcW, ifPcPlus4W;
  logic [31:0] imemInstrW, ifInstrW;
  logic        ifValidW;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model state, index 0 = dutA, index 1 = dutW.
  logic [63:0] mPc  [2];
  int          mCnt [2];
  logic [63:0] mEPc [2][DEPTH];
  logic [31:0] mEIn [2][DEPTH];

  always #5 clk = ~clk;

  // Instruction memory: the four-instruction program at address 0, a simple
  // address hash everywhere else so every word is distinguishable.
  function automatic logic [31:0] memAt(input logic [63:0] a);
    case (a)
      64'd0:   return 32'h00100093;
      64'd4:   return 32'h00200113;
      64'd8:   return 32'h00308193;
      64'd12:  return 32'h00110213;
      default: return {a[15:0], a[31:16]} ^ a[63:32] ^ 32'h5A5A_1234;
    endcase
  endfunction

  assign imemInstrA = memAt(imemAddrA);
  assign imemInstrW = memAt(imemAddrW);

  instruction_fetch #(.RESET_PC(RESET_A), .DEPTH(DEPTH)) dutA (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imemAddrA),
    .imem_instr     (imemInstrA),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .if_valid       (ifValidA),
    .if_ready       (ifReady),
    .if_pc          (ifPcA),
    .if_instr       (ifInstrA),
    .if_pc_plus4    (ifPcPlus4A)
  );

  instruction_fetch #(.RESET_PC(RESET_W), .DEPTH(DEPTH)) dutW (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imemAddrW),
    .imem_instr     (imemInstrW),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .if_valid       (ifValidW),
    .if_ready       (ifReady),
    .if_pc          (ifPcW),
    .if_instr       (ifInstrW),
    .if_pc_plus4    (ifPcPlus4W)
  );

  // Single comparison point: counts every check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One clock edge of the fetch rules for model m, using the inputs that
  // were applied during the cycle.
  task automatic modelStep(input int m, input logic r, input logic rv,
                           input logic [63:0] rp, input logic rdy);
    logic pop;
    logic push;
    pop  = (mCnt[m] > 0) && rdy;
    push = !r && !rv && ((mCnt[m] < DEPTH) || pop);
    if (r) begin
      mCnt[m] = 0;
      mPc[m]  = (m == 0) ? RESET_A : RESET_W;
      mPc[m][1:0] = 2'b00;
    end else if (rv) begin
      mCnt[m] = 0;
      mPc[m]  = {rp[63:2], 2'b00};
    end else begin
      if (pop) begin
        for (int i = 0; i < DEPTH - 1; i++) begin
          mEPc[m][i] = mEPc[m][i+1];
          mEIn[m][i] = mEIn[m][i+1];
        end
        mCnt[m]--;
      end
      if (push) begin
        mEPc[m][mCnt[m]] = mPc[m];
        mEIn[m][mCnt[m]] = memAt(mPc[m]);
        mCnt[m]++;
        mPc[m] = mPc[m] + 64'd4;
      end
    end
  endtask

  // Compare every output of one DUT with what its model predicts.
  task automatic checkDut(input int m);
    logic [63:0] ePc;
    logic [31:0] eIn;
    string       nm;
    nm  = (m == 0) ? "A" : "W";
    ePc = (mCnt[m] > 0) ? mEPc[m][0] : 64'h0;
    eIn = (mCnt[m] > 0) ? mEIn[m][0] : NOP;
    checkOutput({nm, ".imem_addr"}, (m == 0) ? imemAddrA : imemAddrW, mPc[m]);
    checkOutput({nm, ".if_valid"}, {63'h0, (m == 0) ? ifValidA : ifValidW},
                {63'h0, mCnt[m] > 0});
    checkOutput({nm, ".if_pc"}, (m == 0) ? ifPcA : ifPcW, ePc);
    checkOutput({nm, ".if_instr"}, {32'h0, (m == 0) ? ifInstrA : ifInstrW},
                {32'h0, eIn});
    checkOutput({nm, ".if_pc_plus4"}, (m == 0) ? ifPcPlus4A : ifPcPlus4W,
                ePc + 64'd4);
  endtask

  // Drive one cycle of inputs on the falling edge, advance both models on the
  // rising edge, then check both DUTs just after it.
  task automatic applyStimulus(input logic r, input logic rv,
                               input logic [63:0] rp, input logic rdy);
    @(negedge clk);
    rst           = r;
    redirectValid = rv;
    redirectPc    = rp;
    ifReady       = rdy;
    @(posedge clk);
    modelStep(0, r, rv, rp, rdy);
    modelStep(1, r, rv, rp, rdy);
    #1;
    checkDut(0);
    checkDut(1);
  endtask

  initial begin
    logic [63:0] expPc [4];
    logic [31:0] expIn [4];
    expPc = '{64'd0, 64'd4, 64'd8, 64'd12};
    expIn = '{32'h00100093, 32'h00200113, 32'h00308193, 32'h00110213};
    for (int m = 0; m < 2; m++) begin
      mCnt[m] = 0;
      mPc[m]  = 64'h0;
    end

    // Straight-line program with decode always ready; the wrap DUT starts
    // at the top of the address space.
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b1);
    checkOutput("reset.valid", {63'h0, ifValidA}, 64'h0);
    checkOutput("reset.instr", {32'h0, ifInstrA}, {32'h0, NOP});
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
      checkOutput("prog.pc", ifPcA, expPc[i]);
      checkOutput("prog.instr", {32'h0, ifInstrA}, {32'h0, expIn[i]});
      if (i == 0) begin
        checkOutput("wrap.pc", ifPcW, 64'hFFFF_FFFF_FFFF_FFFC);
        checkOutput("wrap.plus4", ifPcPlus4W, 64'h0);
      end else if (i == 1) begin
        checkOutput("wrap.next", ifPcW, 64'h0);
      end
    end

    // Decode stalled right after reset: buffer fills and the PC parks.
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    checkOutput("stall.addr", imemAddrA, 64'd8);
    checkOutput("stall.pc", ifPcA, 64'd0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("resume.pc1", ifPcA, 64'd4);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("resume.pc2", ifPcA, 64'd8);

    // Redirect with a full buffer; the misaligned target is aligned down.
    applyStimulus(1'b0, 1'b1, 64'h43, 1'b0);
    checkOutput("redir.valid", {63'h0, ifValidA}, 64'h0);
    checkOutput("redir.addr", imemAddrA, 64'h40);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("redir.pc", ifPcA, 64'h40);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);

    // Redirect coinciding with a pop while one entry is buffered.
    applyStimulus(1'b0, 1'b1, 64'h200, 1'b1);
    checkOutput("redirpop.valid", {63'h0, ifValidA}, 64'h0);
    checkOutput("redirpop.addr", imemAddrA, 64'h200);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("redirpop.pc", ifPcA, 64'h200);

    // Reset while the buffer is full.
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("midrst.valid", {63'h0, ifValidA}, 64'h0);
    checkOutput("midrst.addr", imemAddrA, 64'h0);
    checkOutput("midrst.instr", {32'h0, ifInstrA}, {32'h0, NOP});
    applyStimulus(1'b0, 1'b0, 64'h0, 1'b1);
    checkOutput("midrst.restart", ifPcA, 64'h0);

    // Random mix of stalls, redirects and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic r;
      logic rv;
      logic rdy;
      logic [63:0] rp;
      r   = ($urandom_range(99) < 2);
      rv  = ($urandom_range(99) < 10);
      rdy = ($urandom_range(99) < 60);
      rp  = {$urandom, $urandom};
      applyStimulus(r, rv, rp, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
